fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the opcode decoder: holds the PC, requests instructions from instruction memory over a req/ack handshake, and presents each instruction to decode with a valid/ready handshake.
- Consumes the decoder's resolution for the issued instruction: Branch, Bne, Jump, the ALU Zero flag, imm16 and jaddr26. From these it computes the next PC.
- Non-pipelined: exactly one instruction is in flight at a time.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- TIMEOUT_CYCLES, 16, wait-cycle limit for imem_ack; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equal to pc.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, sampled when imem_ack=1.
- inst_valid  out  1  inst holds an instruction for decode.
- inst_ready  in  1  decode accepts the instruction.
- inst  out  32  instruction word; inst[31:26] feeds the decoder opcode.
- pc_plus4  out  32  PC of the issued instruction + 4; used for JAL link.
- resolve_valid  in  1  resolution inputs are valid for the issued instruction.
- branch  in  1  BEQ resolution.
- bne  in  1  BNE resolution.
- jump  in  1  J or JAL resolution.
- zero  in  1  ALU zero flag.
- imm16  in  16  branch offset in words.
- jaddr26  in  26  jump target field.
- fetch_err  out  1  sticky fetch timeout flag; driven only with the optional feature, otherwise tied to 0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, inst_valid=0, inst=0, pc_plus4=0, fetch_err=0.
  - Any in-flight request or issued instruction is abandoned.
- State FETCH:
  - imem_req=1 from the first cycle after reset release or after entering FETCH.
  - imem_addr=pc, held stable until imem_ack.
  - On imem_ack: register inst<=imem_rdata and pc_plus4<=pc+4; drop imem_req; go to ISSUE.
  - Latency: an ack in the same cycle as req is legal, giving a minimum of 1 cycle in FETCH.
- State ISSUE:
  - inst_valid=1; inst and pc_plus4 are held stable until inst_ready=1.
  - On inst_ready=1 with resolve_valid=0: go to RESOLVE.
  - On inst_ready=1 with resolve_valid=1 in the same cycle (combinational decode): apply the next-PC rule and go directly to FETCH.
- State RESOLVE:
  - inst_valid=0.
  - Wait for resolve_valid=1, then apply the next-PC rule and go to FETCH.
- Next-PC rule:
  - Priority is jump > (branch & zero) > (bne & ~zero) > sequential.
  - jump: pc <= {pc_plus4[31:28], jaddr26, 2'b00}.
  - Taken branch: pc <= pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00}), computed modulo 2^32 (wrap-around, no trap).
  - Otherwise: pc <= pc_plus4. At pc=32'hFFFF_FFFC this wraps to 0.
  - branch and bne asserted together is illegal; the priority above still resolves it deterministically.
- resolve_valid outside ISSUE/RESOLVE is ignored.
- imem_ack outside FETCH is ignored.
- inst_ready outside ISSUE is ignored.
- pc[1:0] is always 00.
- Total latency: the next fetch request is issued the cycle after resolution.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Enabled:
  - A wait counter clears on entry to FETCH and increments each FETCH cycle without imem_ack.
  - When the count reaches TIMEOUT_CYCLES with no ack, set fetch_err=1 and enter HALT.
  - In HALT: imem_req=0, inst_valid=0, and the state is held until reset.
  - fetch_err is cleared only by rst_n.
  - An ack arriving in the same cycle as the limit is reached wins; no error is flagged.
- Disabled: no counter, no HALT state, fetch_err tied to 0, and FETCH waits indefinitely.

Test Plan:
- Reset release with RESET_PC=0, imem_ack returning the next cycle with 32'h2008_0005 -> imem_addr=0; inst=32'h2008_0005, inst_valid=1, pc_plus4=4.
- Sequential: resolve with all flags 0 after issue at pc=0 -> next imem_addr=4; check pc=32'hFFFF_FFFC wraps to 0.
- BEQ taken: pc_plus4=32'h10, branch=1, zero=1, imm16=16'hFFFE -> next imem_addr=32'h08. Same inputs with zero=0 -> 32'h10.
- BNE taken plus jump priority: pc_plus4=32'h1000_0004, jump=1, bne=1, zero=0, jaddr26=26'h40 -> next imem_addr=32'h1000_0100.
- Handshake/reset: hold inst_ready=0 for 5 cycles -> inst stable. Assert inst_ready and resolve_valid in the same cycle -> FETCH next cycle. Drop rst_n mid-FETCH -> imem_req=0 immediately, restart at RESET_PC.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> fetch_err=1 after 4 cycles, imem_req=0, held until reset.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch, req/ack toward imem and valid/ready toward decode.
// Optional macro FETCH_TIMEOUT_EN adds an imem_ack watchdog that halts with a sticky fetch_err.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  input  logic        resolve_valid,
  input  logic        branch,
  input  logic        bne,
  input  logic        jump,
  input  logic        zero,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr26,
  output logic        fetch_err
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {FETCH, ISSUE, RESOLVE, HALT} state_t;
`else
  typedef enum logic [1:0] {FETCH, ISSUE, RESOLVE} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, br_off;
  logic        resolve_fire, fetch_done;

  assign fetch_done = (state == FETCH) && imem_ack;
  // Reset state is FETCH, so the request is gated by rst_n to stay low while held in reset
  assign imem_req   = (state == FETCH) && rst_n;
  assign imem_addr  = pc;
  assign inst_valid = (state == ISSUE);
  assign br_off     = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    pc_nxt = pc_plus4;
    if (jump)
      pc_nxt = {pc_plus4[31:28], jaddr26, 2'b00};
    else if ((branch && zero) || (bne && !zero))
      pc_nxt = pc_plus4 + br_off;
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;

  // A same-cycle ack beats the limit
  assign timeout_hit = (state == FETCH) && !imem_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state != FETCH || imem_ack) wait_cnt <= '0;
      else                            wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit) fetch_err <= 1'b1;
    end
  end
`else
  assign fetch_err = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_nxt    = state;
    resolve_fire = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ack) state_nxt = ISSUE;
`ifdef FETCH_TIMEOUT_EN
        else if (timeout_hit) state_nxt = HALT;
`endif
      end
      ISSUE: begin
        if (inst_ready) begin
          if (resolve_valid) begin
            resolve_fire = 1'b1;
            state_nxt    = FETCH;
          end else begin
            state_nxt = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        if (resolve_valid) begin
          resolve_fire = 1'b1;
          state_nxt    = FETCH;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      HALT: state_nxt = HALT;
`endif
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= {RESET_PC[31:2], 2'b00};
      inst     <= '0;
      pc_plus4 <= '0;
    end else begin
      state <= state_nxt;
      if (fetch_done) begin
        inst     <= imem_rdata;
        pc_plus4 <= pc + 32'd4;
      end
      if (resolve_fire) pc <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; expected fetch addresses are queued at resolution, popped at fetch.
// Covers FETCH_TIMEOUT_EN when that macro is defined.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, inst_valid, inst_ready, resolve_valid;
  logic        branch, bne, jump, zero, fetch_err;
  logic [31:0] imem_addr, imem_rdata, inst, pc_plus4;
  logic [15:0] imm16;
  logic [25:0] jaddr26;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc_plus4(pc_plus4),
    .resolve_valid(resolve_valid), .branch(branch), .bne(bne), .jump(jump), .zero(zero),
    .imm16(imm16), .jaddr26(jaddr26), .fetch_err(fetch_err)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Wait (bounded) for a request, ack it with rdata; returns address seen and popped expectation
  task automatic fetch(input logic [31:0] rdata, output logic [31:0] seen,
                       output logic [31:0] expv, output bit got);
    got  = 1'b0;
    expv = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    seen = imem_addr;
    if (got) begin
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = '0;
    end
  endtask

  // Resolve the issued instruction; the independent next-PC model pushes the expected address
  task automatic step(input bit comb, input bit j, input bit b, input bit bn, input bit z,
                      input logic [15:0] imm, input logic [25:0] ja);
    logic [31:0] p4, nxt;
    p4 = model_pc + 32'd4;
    if (j)                      nxt = {p4[31:28], ja, 2'b00};
    else if ((b && z) || (bn && !z)) nxt = p4 + {{14{imm[15]}}, imm, 2'b00};
    else                        nxt = p4;
    exp_q.push_back(nxt);
    model_pc = nxt;
    jump = j; branch = b; bne = bn; zero = z; imm16 = imm; jaddr26 = ja;
    if (comb) begin
      inst_ready = 1'b1; resolve_valid = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0; resolve_valid = 1'b0;
    end else begin
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      @(negedge clk);
      resolve_valid = 1'b1;
      @(negedge clk);
      resolve_valid = 1'b0;
    end
    jump = 0; branch = 0; bne = 0; zero = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; imem_ack = 0; imem_rdata = '0; inst_ready = 0; resolve_valid = 0;
    branch = 0; bne = 0; jump = 0; zero = 0; imm16 = '0; jaddr26 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req, inst_valid, fetch_err} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl req/valid/err=%b exp=000", {imem_req, inst_valid, fetch_err});
    end
    checks++;
    if ({inst, pc_plus4} !== 64'd0) begin
      failures++; $display("FAIL reset_data inst=%h pc_plus4=%h exp=0", inst, pc_plus4);
    end
    rst_n = 1'b1;
    exp_q.delete(); model_pc = 32'h0; exp_q.push_back(32'h0);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL reset_release req=%b addr=%h exp=1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] a, e; bit g;
    @(negedge clk);
    fetch(32'h2008_0005, a, e, g);
    checks++;
    if (!g || a !== e) begin failures++; $display("FAIL seq_addr0 got=%h exp=%h", a, e); end
    checks++;
    if (inst !== 32'h2008_0005 || inst_valid !== 1'b1 || pc_plus4 !== 32'h4) begin
      failures++; $display("FAIL seq_issue0 inst=%h valid=%b p4=%h exp=20080005/1/4", inst, inst_valid, pc_plus4);
    end
    step(0, 0, 0, 0, 0, 16'h0, 26'h0);
    fetch(32'h0000_0001, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'h4) begin failures++; $display("FAIL seq_addr4 got=%h exp=%h", a, e); end
    step(1, 0, 1, 0, 1, 16'hFFFD, 26'h0);
    fetch(32'h0000_0002, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'hFFFF_FFFC) begin failures++; $display("FAIL seq_addr_top got=%h exp=%h", a, e); end
    checks++;
    if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL seq_p4_wrap got=%h exp=0", pc_plus4); end
    step(0, 0, 0, 0, 0, 16'h0, 26'h0);
    fetch(32'h0000_0003, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'h0) begin failures++; $display("FAIL seq_wrap got=%h exp=%h", a, e); end
  endtask

  task automatic test_beq;
    logic [31:0] a, e; bit g;
    step(0, 0, 0, 0, 0, 16'h0, 26'h0); fetch(32'h1, a, e, g);
    step(1, 0, 0, 0, 0, 16'h0, 26'h0); fetch(32'h2, a, e, g);
    step(0, 0, 0, 0, 0, 16'h0, 26'h0); fetch(32'h1000_0000, a, e, g);
    checks++;
    if (!g || a !== 32'hC || pc_plus4 !== 32'h10) begin
      failures++; $display("FAIL beq_setup addr=%h p4=%h exp=c/10", a, pc_plus4);
    end
    step(1, 0, 1, 0, 1, 16'hFFFE, 26'h0);
    fetch(32'h3, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'h8) begin failures++; $display("FAIL beq_taken got=%h exp=%h", a, e); end
    step(0, 0, 0, 0, 0, 16'h0, 26'h0); fetch(32'h4, a, e, g);
    step(0, 0, 1, 0, 0, 16'hFFFE, 26'h0);
    fetch(32'h5, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'h10) begin failures++; $display("FAIL beq_not_taken got=%h exp=%h", a, e); end
  endtask

  task automatic test_jump_priority;
    logic [31:0] a, e; bit g;
    step(0, 1, 0, 0, 0, 16'h0, 26'h3FF_FFFF);
    fetch(32'h6, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'h0FFF_FFFC) begin failures++; $display("FAIL jmp_far got=%h exp=%h", a, e); end
    step(1, 1, 0, 0, 0, 16'h0, 26'h0);
    fetch(32'h7, a, e, g);
    checks++;
    if (!g || a !== e || pc_plus4 !== 32'h1000_0004) begin
      failures++; $display("FAIL jmp_region got=%h p4=%h exp=%h/10000004", a, pc_plus4, e);
    end
    step(0, 1, 0, 1, 0, 16'h0007, 26'h40);
    fetch(32'h8, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'h1000_0100) begin failures++; $display("FAIL jmp_over_bne got=%h exp=%h", a, e); end
    step(1, 0, 0, 1, 0, 16'h0003, 26'h0);
    fetch(32'h9, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'h1000_0110) begin failures++; $display("FAIL bne_taken got=%h exp=%h", a, e); end
    step(0, 0, 1, 1, 1, 16'h0001, 26'h0);
    fetch(32'hA, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'h1000_0118) begin failures++; $display("FAIL beq_bne_both got=%h exp=%h", a, e); end
    step(1, 0, 0, 1, 1, 16'h0005, 26'h0);
    fetch(32'hB, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'h1000_011C) begin failures++; $display("FAIL bne_not_taken got=%h exp=%h", a, e); end
  endtask

  task automatic test_handshake;
    logic [31:0] a, e; bit g;
    step(1, 0, 0, 0, 0, 16'h0, 26'h0);
    // Stalled memory: request and address hold; stray decode-side inputs are ignored
    inst_ready = 1'b1; resolve_valid = 1'b1; jump = 1'b1; jaddr26 = 26'h123;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_q[0]) begin
        failures++; $display("FAIL hs_req_hold cyc=%0d req=%b addr=%h exp=1/%h", i, imem_req, imem_addr, exp_q[0]);
      end
      @(negedge clk);
    end
    inst_ready = 1'b0; resolve_valid = 1'b0; jump = 1'b0;
    fetch(32'hABCD_1234, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'h1000_0120) begin failures++; $display("FAIL hs_addr got=%h exp=%h", a, e); end
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (inst !== 32'hABCD_1234 || inst_valid !== 1'b1 || pc_plus4 !== 32'h1000_0124) begin
        failures++; $display("FAIL hs_stall cyc=%0d inst=%h valid=%b p4=%h", i, inst, inst_valid, pc_plus4);
      end
    end
    imem_ack = 1'b0; imem_rdata = '0;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL hs_resolve_wait valid=%b req=%b exp=0/0", inst_valid, imem_req);
    end
    model_pc = 32'h1000_0124; exp_q.push_back(model_pc);
    resolve_valid = 1'b1;
    @(negedge clk);
    resolve_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL hs_refetch req=%b exp=1", imem_req); end
    fetch(32'hC, a, e, g);
    checks++;
    if (!g || a !== e) begin failures++; $display("FAIL hs_addr2 got=%h exp=%h", a, e); end
    step(1, 0, 0, 0, 0, 16'h0, 26'h0);
    checks++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h1000_0128) begin
      failures++; $display("FAIL hs_comb req=%b valid=%b addr=%h exp=1/0/10000128", imem_req, inst_valid, imem_addr);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] a, e; bit g;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || pc_plus4 !== 32'h0) begin
      failures++; $display("FAIL rst_mid req=%b valid=%b inst=%h p4=%h exp=0", imem_req, inst_valid, inst, pc_plus4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); model_pc = 32'h0; exp_q.push_back(32'h0);
    fetch(32'hD, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'h0) begin failures++; $display("FAIL rst_restart got=%h exp=%h", a, e); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout;
    step(1, 0, 0, 0, 0, 16'h0, 26'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
      failures++; $display("FAIL to_before err=%b req=%b exp=0/1", fetch_err, imem_req);
    end
    @(negedge clk);
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      failures++; $display("FAIL to_hit err=%b req=%b valid=%b exp=1/0/0", fetch_err, imem_req, inst_valid);
    end
    imem_ack = 1'b1;
    repeat (5) @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      failures++; $display("FAIL to_held err=%b req=%b valid=%b exp=1/0/0", fetch_err, imem_req, inst_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); model_pc = 32'h0;
    repeat (3) @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hFACE_0001;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (fetch_err !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'hFACE_0001) begin
      failures++; $display("FAIL to_ack_wins err=%b valid=%b inst=%h exp=0/1/face0001", fetch_err, inst_valid, inst);
    end
  endtask
`else
  task automatic test_timeout;
    logic [31:0] a, e; bit g;
    step(1, 0, 0, 0, 0, 16'h0, 26'h0);
    repeat (20) @(negedge clk);
    checks++;
    if (fetch_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_q[0]) begin
      failures++; $display("FAIL no_timeout err=%b req=%b addr=%h exp=0/1/%h", fetch_err, imem_req, imem_addr, exp_q[0]);
    end
    fetch(32'hE, a, e, g);
    checks++;
    if (!g || a !== e || a !== 32'h4) begin failures++; $display("FAIL late_ack got=%h exp=%h", a, e); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_beq();
    test_jump_priority();
    test_handshake();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
